// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared stage-state encoding and default widths for MIPS pipeline registers
package mips_pipe_pkg;
  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,
    STAGE_FULL  = 2'd1,
    STAGE_SKID  = 2'd2
  } stage_state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF = 32;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: enable-loaded {pc,data} register with valid bit; clr has priority over ld
// ports: clk, rst_n (async low), ld (load d), clr (invalidate, zero q when CLEAR), d, valid, q
module pipe_skid_entry #(
  parameter int W = 64,
  parameter bit CLEAR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      if (CLEAR) q <= '0;
    end else if (ld) begin
      valid <= 1'b1;
      q <= d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid, stall, and flush with NOP bubble
// ports: clk, rst_n, flush, stall, in_valid/in_ready/in_pc/in_data, out_valid/out_ready/out_pc/out_data
// optional: PIPE_STAGE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  localparam int W = PC_W + DATA_W;
  stage_state_t st, st_n;
  logic in_fire, out_fire, main_ld, main_src_skid, main_clr, skid_ld, skid_clr, skid_v;
  logic [W-1:0] skid_q;
  assign in_ready = !skid_v;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= STAGE_EMPTY;
    else st <= st_n;
  always_comb begin
    st_n = st;
    main_ld = 1'b0;
    main_src_skid = 1'b0;
    main_clr = 1'b0;
    skid_ld = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      st_n = STAGE_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else
      case (st)
        STAGE_EMPTY: if (in_fire) begin
          main_ld = 1'b1;
          st_n = STAGE_FULL;
        end
        STAGE_FULL: begin
          main_ld = in_fire && out_fire;
          skid_ld = in_fire && !out_fire;
          main_clr = !in_fire && out_fire;
          st_n = skid_ld ? STAGE_SKID : main_clr ? STAGE_EMPTY : STAGE_FULL;
        end
        STAGE_SKID: if (out_fire) begin
          main_ld = 1'b1;
          main_src_skid = 1'b1;
          skid_clr = 1'b1;
          st_n = STAGE_FULL;
        end
        default: st_n = STAGE_EMPTY;
      endcase
  end
  pipe_skid_entry #(.W(W), .CLEAR(CLEAR_ON_FLUSH)) u_main (
    .clk(clk), .rst_n(rst_n), .ld(main_ld), .clr(main_clr),
    .d(main_src_skid ? skid_q : {in_pc, in_data}),
    .valid(out_valid), .q({out_pc, out_data})
  );
  pipe_skid_entry #(.W(W), .CLEAR(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .ld(skid_ld), .clr(skid_clr),
    .d({in_pc, in_data}), .valid(skid_v), .q(skid_q)
  );
`ifdef PIPE_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && st != STAGE_EMPTY && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
`endif
endmodule
